operand_feeder: RTL and testbench
=================================

OPERAND_FEEDER -- requirements
Module: operand_feeder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning operand width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning buffer entries, power of two, at least 2.
REQ-003 The block SHALL have parameter NUM_OPS, default 16, meaning operand pairs consumed per run, at least 1.
REQ-004 The block SHALL have a single clock, and its reset SHALL be asynchronous and active-high, with the ports named clk and rst.
REQ-005 The block SHALL have the following ports:
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- inner_rst  in  1  synchronous clear, same effect as rst, applied at the clock edge.
- start  in  1  begins a run.
- wr_en  in  1  push request.
- wr_a  in  DATA_W  operand A to push.
- wr_b  in  DATA_W  operand B to push.
- ld_mult  in  1  consumer load strobe.
- can_mult  out  1  head pair valid and offered to the consumer.
- a_out  out  DATA_W  head operand A.
- b_out  out  DATA_W  head operand B.
- full  out  1  buffer holds DEPTH entries.
- empty  out  1  buffer holds 0 entries.
- done  out  1  run complete.
- wr_err  out  1  sticky flag for a write attempted while full.

Function
REQ-006 The block SHALL implement a state machine with the states IDLE, FEED and DONE.
REQ-007 In IDLE, start=1 SHALL move the state to FEED and clear the consumed counter; in FEED and DONE, start SHALL be ignored, except that in DONE start=1 SHALL return the state to FEED and clear the consumed counter.
REQ-008 can_mult SHALL be combinational and equal to (state==FEED) && !empty.
REQ-009 A pop SHALL occur on a clock edge where ld_mult && can_mult; ld_mult with can_mult=0 SHALL be ignored, with no pointer or counter change.
REQ-010 a_out and b_out SHALL present the head entry combinationally (first-word fall-through) whenever empty=0, and SHALL be 0 when empty=1.
REQ-011 A push SHALL occur on a clock edge where wr_en && (!full || pop in the same cycle); pushes SHALL be accepted in every state.
REQ-012 A simultaneous push and pop SHALL leave the occupancy unchanged, with both pointers advancing.
REQ-013 wr_en && full with no pop SHALL drop the data, leave the buffer unchanged, and set wr_err; wr_err SHALL stay set until rst or inner_rst.
REQ-014 The pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-015 The occupancy counter SHALL be log2(DEPTH)+1 bits; full SHALL equal (count==DEPTH) and empty SHALL equal (count==0).
REQ-016 The consumed counter SHALL increment by 1 on each pop.
REQ-017 The pop that makes the consumed count equal NUM_OPS SHALL move the state FEED->DONE at the same edge, so can_mult=0 from the next cycle.
REQ-018 done SHALL be 1 exactly while the state is DONE.
REQ-019 Entries left in the buffer at DONE SHALL be retained for the next run.
REQ-020 Pop-to-next-valid latency SHALL be zero: if a second entry exists, can_mult SHALL stay 1 and a_out/b_out SHALL show that entry in the cycle after the pop.
REQ-021 Push-to-offer latency SHALL be one cycle: a push into an empty buffer during FEED SHALL give can_mult=1 in the next cycle.

Reset
REQ-022 rst (asynchronously) and inner_rst (at the clock edge) SHALL set state=IDLE, both pointers=0, occupancy=0, consumed=0 and wr_err=0.
REQ-023 After reset the outputs SHALL be can_mult=0, a_out=0, b_out=0, full=0, empty=1, done=0 and wr_err=0.
REQ-024 inner_rst SHALL take priority over a push, a pop and start occurring in the same cycle.
REQ-025 A reset asserted mid-run SHALL discard all buffered data.
REQ-026 Buffer storage contents need not be cleared by reset.

Verification
REQ-027 Reset, then push (3,5) in IDLE, then pulse start -> can_mult=1, a_out=3 and b_out=5 in the cycle after start; hold ld_mult for 1 cycle -> empty=1 and can_mult=0.
REQ-028 Push 4 pairs with DEPTH=4 -> full=1; push a 5th with no pop -> data dropped, wr_err=1, and the buffer still holds the first 4 pairs in order.
REQ-029 With full=1, wr_en and ld_mult in the same cycle -> full stays 1 and the new pair is at the tail; after 4 more pops the outputs appear in FIFO order across the pointer wrap.
REQ-030 NUM_OPS=16, continuous push/pop stream -> exactly 16 pops, then done=1 and can_mult=0; a 17th buffered pair is retained; start -> FEED and that pair is offered.
REQ-031 ld_mult=1 while empty in FEED -> no counter change and done stays 0; inner_rst mid-run with 2 pairs buffered -> IDLE, empty=1, consumed=0, wr_err=0.

Source files
------------

// File: rtl/operand_feeder.sv
// Operand-pair FIFO feeding a multiplier: first-word fall-through head,
// run control that offers exactly NUM_OPS pairs per run, sticky overflow flag.
module operand_feeder #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int NUM_OPS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inner_rst,
    input  logic              start,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_a,
    input  logic [DATA_W-1:0] wr_b,
    input  logic              ld_mult,
    output logic              can_mult,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              full,
    output logic              empty,
    output logic              done,
    output logic              wr_err
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int OPS_W = $clog2(NUM_OPS + 1);

    localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
    localparam logic [OPS_W-1:0] LAST_OP  = OPS_W'(NUM_OPS - 1);

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DONE} state_t;

    state_t            state_q;
    logic [AW-1:0]     rd_q, wr_q;
    logic [CW-1:0]     count_q;
    logic [OPS_W-1:0]  consumed_q;
    logic              wr_err_q;

    logic [DATA_W-1:0] mem_a_q [DEPTH];
    logic [DATA_W-1:0] mem_b_q [DEPTH];

    logic pop, push;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign can_mult = (state_q == S_FEED) && !empty;
    assign pop      = ld_mult && can_mult;
    // A pop frees the slot this cycle, so a push into a full buffer is legal then.
    assign push     = wr_en && (!full || pop);
    assign a_out    = empty ? '0 : mem_a_q[rd_q];
    assign b_out    = empty ? '0 : mem_b_q[rd_q];
    assign done     = (state_q == S_DONE);
    assign wr_err   = wr_err_q;

    always_ff @(posedge clk) begin
        if (push && !inner_rst) begin
            mem_a_q[wr_q] <= wr_a;
            mem_b_q[wr_q] <= wr_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
            consumed_q <= '0;
            wr_err_q   <= 1'b0;
        end else if (inner_rst) begin
            state_q    <= S_IDLE;
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
            consumed_q <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
            if (wr_en && full && !pop) wr_err_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_FEED;
                        consumed_q <= '0;
                    end
                end
                S_FEED: begin
                    if (pop) begin
                        consumed_q <= consumed_q + OPS_W'(1);
                        if (consumed_q == LAST_OP) state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state_q    <= S_FEED;
                        consumed_q <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_operand_feeder.sv
// Directed bench for operand_feeder with default parameters (DATA_W=8, DEPTH=4, NUM_OPS=16).
module tb_operand_feeder;
    logic       clk = 1'b0;
    logic       rst, inner_rst, start, wr_en, ld_mult;
    logic [7:0] wr_a, wr_b;
    logic       can_mult, full, empty, done, wr_err;
    logic [7:0] a_out, b_out;

    int n_chk  = 0;
    int n_fail = 0;

    operand_feeder dut (
        .clk(clk), .rst(rst), .inner_rst(inner_rst), .start(start),
        .wr_en(wr_en), .wr_a(wr_a), .wr_b(wr_b), .ld_mult(ld_mult),
        .can_mult(can_mult), .a_out(a_out), .b_out(b_out),
        .full(full), .empty(empty), .done(done), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        start = 0; wr_en = 0; ld_mult = 0; inner_rst = 0; wr_a = 0; wr_b = 0;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        wr_en = 1; wr_a = a; wr_b = b;
        tick();
        wr_en = 0;
    endtask

    initial begin
        rst = 1;
        idle_in();
        tick(); tick();
        // reset state
        chk("rst_can_mult", can_mult, 0);
        chk("rst_a_out", a_out, 0);
        chk("rst_b_out", b_out, 0);
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        chk("rst_done", done, 0);
        chk("rst_wr_err", wr_err, 0);
        rst = 0;
        tick();

        // push (3,5) while idle, then start
        push(8'd3, 8'd5);
        chk("idle_no_offer", can_mult, 0);
        chk("idle_empty", empty, 0);
        start = 1; tick(); start = 0;
        chk("start_can_mult", can_mult, 1);
        chk("start_a", a_out, 3);
        chk("start_b", b_out, 5);
        ld_mult = 1; tick(); ld_mult = 0;
        chk("pop1_empty", empty, 1);
        chk("pop1_can_mult", can_mult, 0);
        chk("pop1_a_zero", a_out, 0);

        // ld_mult while empty in FEED is ignored
        ld_mult = 1; tick(); ld_mult = 0;
        chk("ld_empty_done", done, 0);
        chk("ld_empty_empty", empty, 1);

        // clean slate, then fill to full in IDLE
        inner_rst = 1; tick(); inner_rst = 0;
        chk("irst1_empty", empty, 1);
        for (int i = 0; i < 4; i++) begin
            chk("fill_not_full", full, 0);
            push(8'(10 + i), 8'(20 + i));
        end
        chk("fill_full", full, 1);
        chk("fill_wr_err0", wr_err, 0);
        push(8'd99, 8'd98);
        chk("ovf_wr_err", wr_err, 1);
        chk("ovf_full", full, 1);
        chk("ovf_head_a", a_out, 10);

        // simultaneous push+pop while full, then drain across the wrap
        start = 1; tick(); start = 0;
        chk("feed_head_a", a_out, 10);
        wr_en = 1; wr_a = 8'd30; wr_b = 8'd40; ld_mult = 1;
        tick();
        wr_en = 0; ld_mult = 0;
        chk("pp_full", full, 1);
        chk("pp_head_a", a_out, 11);
        begin
            logic [7:0] exp_a [4];
            logic [7:0] exp_b [4];
            exp_a = '{8'd11, 8'd12, 8'd13, 8'd30};
            exp_b = '{8'd21, 8'd22, 8'd23, 8'd40};
            for (int i = 0; i < 4; i++) begin
                chk("drain_can_mult", can_mult, 1);
                chk("drain_a", a_out, exp_a[i]);
                chk("drain_b", b_out, exp_b[i]);
                ld_mult = 1; tick(); ld_mult = 0;
            end
        end
        chk("drain_empty", empty, 1);
        chk("wr_err_sticky", wr_err, 1);

        // inner_rst mid-run with 2 pairs buffered beats push/pop/start
        push(8'd50, 8'd60);
        push(8'd51, 8'd61);
        chk("mid_can_mult", can_mult, 1);
        inner_rst = 1; wr_en = 1; wr_a = 8'd77; wr_b = 8'd78; ld_mult = 1; start = 1;
        tick();
        idle_in();
        chk("irst_empty", empty, 1);
        chk("irst_can_mult", can_mult, 0);
        chk("irst_wr_err", wr_err, 0);
        chk("irst_done", done, 0);
        chk("irst_a", a_out, 0);

        // 16-op streaming run; 17th pair stays buffered
        start = 1; tick(); start = 0;
        push(8'd1, 8'd101);
        for (int k = 1; k <= 16; k++) begin
            chk("run_can_mult", can_mult, 1);
            chk("run_a", a_out, 8'(k));
            chk("run_done0", done, 0);
            wr_en = 1; wr_a = 8'(k + 1); wr_b = 8'(k + 101); ld_mult = 1;
            tick();
        end
        idle_in();
        chk("run_done", done, 1);
        chk("run_can_mult0", can_mult, 0);
        chk("run_retained", empty, 0);
        chk("run_ret_a", a_out, 17);
        ld_mult = 1; tick(); ld_mult = 0;
        chk("done_ld_ignored", empty, 0);
        start = 1; tick(); start = 0;
        chk("rerun_done", done, 0);
        chk("rerun_can_mult", can_mult, 1);
        chk("rerun_a", a_out, 17);
        chk("rerun_b", b_out, 117);
        ld_mult = 1; tick(); ld_mult = 0;
        chk("rerun_empty", empty, 1);

        // asynchronous reset away from the clock edge
        push(8'd5, 8'd6);
        chk("async_pre", empty, 0);
        #2 rst = 1;
        #1;
        chk("async_empty", empty, 1);
        chk("async_can_mult", can_mult, 0);
        rst = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
